// File: rtl/fp_cmp_stage_if.sv
// Bundles the issue, comparator, writeback and flag signals of fp_cmp_stage.
// The stage itself uses the slave modport; the issuing/consuming side uses master.
interface fp_cmp_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [4:0]  in_rd;
  logic [32:0] in_a;
  logic [32:0] in_b;

  logic [32:0] cmp_a;
  logic [32:0] cmp_b;
  logic        cmp_signaling;
  logic        cmp_lt;
  logic        cmp_eq;
  logic [4:0]  cmp_exc;

  logic        out_valid;
  logic        out_ready;
  logic [32:0] out_data;
  logic [4:0]  out_rd;
  logic [4:0]  out_exc;

  logic [4:0]  fflags_acc;
  logic        fflags_clr;

  modport slave (
    input  in_valid, in_op, in_rd, in_a, in_b,
    output in_ready,
    output cmp_a, cmp_b, cmp_signaling,
    input  cmp_lt, cmp_eq, cmp_exc,
    output out_valid, out_data, out_rd, out_exc,
    input  out_ready,
    output fflags_acc,
    input  fflags_clr
  );

  modport master (
    output in_valid, in_op, in_rd, in_a, in_b,
    input  in_ready,
    input  cmp_a, cmp_b, cmp_signaling,
    output cmp_lt, cmp_eq, cmp_exc,
    input  out_valid, out_data, out_rd, out_exc,
    output out_ready,
    input  fflags_acc,
    output fflags_clr
  );
endinterface

// File: rtl/fp_cmp_stage.sv
// Single-precision (recoded, 33-bit) compare / min / max writeback stage.
// Operands are forwarded to an external comparator; its lt/eq/exc results are
// turned into FEQ/FLT/FLE/FMIN/FMAX results and registered with a 1-cycle latency.
// Optional build macro FP_CMP_STAGE_SKID_EN selects a 2-entry (main + skid) output
// buffer with a registered in_ready; the default is a single output register.
module fp_cmp_stage (
  input logic           clk_i,
  input logic           rst_i,
  fp_cmp_stage_if.slave bus
);

  localparam logic [2:0]  OpFeq    = 3'd0;
  localparam logic [2:0]  OpFlt    = 3'd1;
  localparam logic [2:0]  OpFle    = 3'd2;
  localparam logic [2:0]  OpFmin   = 3'd3;
  localparam logic [2:0]  OpFmax   = 3'd4;
  localparam logic [32:0] CanonNan = 33'h0E0400000;
  localparam logic [4:0]  ExcNv    = 5'h10;

  typedef struct packed {
    logic [32:0] data;
    logic [4:0]  rd;
    logic [4:0]  exc;
  } res_t;

  logic        a_nan, b_nan, is_min;
  logic [32:0] minmax;
  res_t        res;
  logic        accept, out_fire;
  logic        out_valid_q, out_valid_d;
  res_t        main_q, main_d;
  logic [4:0]  fflags_q, fflags_d;

  assign bus.cmp_a         = bus.in_a;
  assign bus.cmp_b         = bus.in_b;
  assign bus.cmp_signaling = (bus.in_op == OpFlt) || (bus.in_op == OpFle);

  // Signaling-ness only matters to the comparator's exception flags, so only the
  // NaN class is needed here.
  assign a_nan  = bus.in_a[31:29] == 3'b111;
  assign b_nan  = bus.in_b[31:29] == 3'b111;
  assign is_min = bus.in_op == OpFmin;

  // Min/max selection, including NaN handling and the signed-zero tie-break.
  always_comb begin
    minmax = bus.in_b;
    if (a_nan && b_nan) begin
      minmax = CanonNan;
    end else if (a_nan) begin
      minmax = bus.in_b;
    end else if (b_nan) begin
      minmax = bus.in_a;
    end else if (bus.cmp_eq && (bus.in_a[32] != bus.in_b[32])) begin
      // min prefers the negative operand, max the positive one
      minmax = (bus.in_a[32] == is_min) ? bus.in_a : bus.in_b;
    end else if (is_min) begin
      minmax = bus.cmp_lt ? bus.in_a : bus.in_b;
    end else begin
      minmax = bus.cmp_lt ? bus.in_b : bus.in_a;
    end
  end

  // Result decode per opcode; illegal opcodes report invalid-operation.
  always_comb begin
    res.data = '0;
    res.rd   = bus.in_rd;
    res.exc  = bus.cmp_exc;
    case (bus.in_op)
      OpFeq:          res.data = {32'b0, bus.cmp_eq};
      OpFlt:          res.data = {32'b0, bus.cmp_lt};
      OpFle:          res.data = {32'b0, bus.cmp_lt | bus.cmp_eq};
      OpFmin, OpFmax: res.data = minmax;
      default: begin
        res.data = '0;
        res.exc  = ExcNv;
      end
    endcase
  end

  assign out_fire = out_valid_q & bus.out_ready;
  assign accept   = bus.in_valid & bus.in_ready;

`ifdef FP_CMP_STAGE_SKID_EN
  logic skid_full_q, skid_full_d;
  logic in_ready_q, in_ready_d;
  res_t skid_q, skid_d;

  assign bus.in_ready = in_ready_q & ~rst_i;

  // Main/skid buffer next state: the skid entry only fills when main is stalled.
  always_comb begin
    out_valid_d = out_valid_q;
    main_d      = main_q;
    skid_d      = skid_q;
    skid_full_d = skid_full_q;
    if (skid_full_q) begin
      if (out_fire) begin
        main_d      = skid_q;
        skid_full_d = 1'b0;
      end
    end else if (accept) begin
      if (!out_valid_q || out_fire) begin
        main_d      = res;
        out_valid_d = 1'b1;
      end else begin
        skid_d      = res;
        skid_full_d = 1'b1;
      end
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end
    in_ready_d = ~skid_full_d;
  end

  // Skid state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      skid_q      <= '0;
      skid_full_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      skid_q      <= skid_d;
      skid_full_q <= skid_full_d;
      in_ready_q  <= in_ready_d;
    end
  end
`else
  assign bus.in_ready = (~out_valid_q | bus.out_ready) & ~rst_i;

  // Single output register: load on accept, otherwise drain on handshake.
  always_comb begin
    out_valid_d = out_valid_q;
    main_d      = main_q;
    if (accept) begin
      main_d      = res;
      out_valid_d = 1'b1;
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end
  end
`endif

  // Accrued flags: clear takes effect before this cycle's handshake is ORed in.
  always_comb begin
    fflags_d = bus.fflags_clr ? 5'h00 : fflags_q;
    if (out_fire) begin
      fflags_d = fflags_d | main_q.exc;
    end
  end

  // Output and flag registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      main_q      <= '0;
      fflags_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      main_q      <= main_d;
      fflags_q    <= fflags_d;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = main_q.data;
  assign bus.out_rd     = main_q.rd;
  assign bus.out_exc    = main_q.exc;
  assign bus.fflags_acc = fflags_q;

endmodule

// File: tb/tb_fp_cmp_stage.sv
// Self-checking bench for fp_cmp_stage: directed vector table, hand-written
// stall/flag/reset sequences, and a randomized scoreboard run.
module tb_fp_cmp_stage;

  localparam logic [32:0] CANON = 33'h0E0400000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp_cmp_stage_if bus ();

  fp_cmp_stage dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: result of one operation straight from the stage's rules.
  function automatic void model(input logic [2:0] op, input logic [32:0] a, input logic [32:0] b,
                                input logic lt, input logic eq, input logic [4:0] exc,
                                output logic [32:0] d, output logic [4:0] e);
    bit an, bn, neg_a;
    an    = (a[31:29] == 3'b111);
    bn    = (b[31:29] == 3'b111);
    neg_a = a[32];
    d     = '0;
    e     = exc;
    if (op == 3'd0) d = {32'b0, eq};
    else if (op == 3'd1) d = {32'b0, lt};
    else if (op == 3'd2) d = {32'b0, lt | eq};
    else if (op == 3'd3 || op == 3'd4) begin
      if (an && bn) d = CANON;
      else if (an) d = b;
      else if (bn) d = a;
      else if (eq && a[32] != b[32]) begin
        if (op == 3'd3) d = neg_a ? a : b;
        else d = neg_a ? b : a;
      end else if (op == 3'd3) d = lt ? a : b;
      else d = lt ? b : a;
    end else begin
      d = '0;
      e = 5'h10;
    end
  endfunction

  typedef struct packed {
    logic [2:0]  op;
    logic [32:0] a;
    logic [32:0] b;
    logic        lt;
    logic        eq;
    logic [4:0]  exc;
    logic [4:0]  rd;
    logic [32:0] exp_d;
    logic [4:0]  exp_e;
  } vec_t;

  typedef struct packed {
    logic [32:0] d;
    logic [4:0]  rd;
    logic [4:0]  e;
  } exp_t;

  vec_t vecs[14];
  exp_t sb[$];

  task automatic drive_op(input logic [2:0] op, input logic [32:0] a, input logic [32:0] b,
                          input logic lt, input logic eq, input logic [4:0] exc,
                          input logic [4:0] rd);
    bus.in_op   = op;
    bus.in_a    = a;
    bus.in_b    = b;
    bus.cmp_lt  = lt;
    bus.cmp_eq  = eq;
    bus.cmp_exc = exc;
    bus.in_rd   = rd;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b1;  // must be ignored while in reset
    @(negedge clk);
    chk("in_ready_in_reset", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.fflags_clr = 1'b0;
  endtask

  function automatic logic [32:0] pick_operand();
    logic [31:0] r;
    logic [32:0] v;
    r = $urandom;
    case ($urandom_range(0, 5))
      0: v = 33'h000000000;
      1: v = 33'h100000000;
      2: v = CANON;
      3: v = {1'b0, 3'b111, r[28:0]};
      4: v = {r[0], 32'h80000000 ^ {4'h0, r[27:0]}};
      default: v = {1'($urandom), r};
    endcase
    return v;
  endfunction

  initial begin
    int acc_stall, k_in, k_out, cyc, lt_eq;
    logic [32:0] ed;
    logic [4:0] ee, fl;
    logic fire, acc;
    exp_t head;

    bus.in_valid = 0; bus.out_ready = 0; bus.fflags_clr = 0;
    drive_op(3'd0, '0, '0, 1'b0, 1'b0, 5'h0, 5'h0);

    //            op    a              b              lt eq exc    rd     exp_d          exp_e
    vecs[0]  = '{3'd1, 33'h080000000, 33'h080800000, 1, 0, 5'h00, 5'd1,  33'h1,         5'h00};
    vecs[1]  = '{3'd3, 33'h100000000, 33'h000000000, 0, 1, 5'h00, 5'd2,  33'h100000000, 5'h00};
    vecs[2]  = '{3'd4, 33'h100000000, 33'h000000000, 0, 1, 5'h00, 5'd3,  33'h000000000, 5'h00};
    vecs[3]  = '{3'd4, 33'h0E0000001, 33'h180000000, 0, 0, 5'h10, 5'd4,  33'h180000000, 5'h10};
    vecs[4]  = '{3'd3, CANON,         CANON,         0, 0, 5'h00, 5'd5,  CANON,         5'h00};
    vecs[5]  = '{3'd6, 33'h080000000, 33'h080800000, 1, 0, 5'h03, 5'd6,  33'h0,         5'h10};
    vecs[6]  = '{3'd0, 33'h080000000, 33'h080000000, 0, 1, 5'h00, 5'd7,  33'h1,         5'h00};
    vecs[7]  = '{3'd2, 33'h080000000, 33'h080000000, 0, 1, 5'h00, 5'd8,  33'h1,         5'h00};
    vecs[8]  = '{3'd2, CANON,         33'h080000000, 0, 0, 5'h10, 5'd9,  33'h0,         5'h10};
    vecs[9]  = '{3'd3, 33'h080800000, 33'h080000000, 0, 0, 5'h00, 5'd10, 33'h080000000, 5'h00};
    vecs[10] = '{3'd4, 33'h080800000, 33'h080000000, 0, 0, 5'h01, 5'd11, 33'h080800000, 5'h01};
    vecs[11] = '{3'd3, 33'h080000000, CANON,         0, 0, 5'h00, 5'd12, 33'h080000000, 5'h00};
    vecs[12] = '{3'd7, 33'h080000000, 33'h080000000, 0, 1, 5'h00, 5'd13, 33'h0,         5'h10};
    vecs[13] = '{3'd5, 33'h080000000, 33'h080000000, 0, 0, 5'h00, 5'd14, 33'h0,         5'h10};

    do_reset();
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    chk("rst_out_rd", 64'(bus.out_rd), 64'd0);
    chk("rst_out_exc", 64'(bus.out_exc), 64'd0);
    chk("rst_fflags", 64'(bus.fflags_acc), 64'd0);
    chk("rst_after_accept_in_reset", 64'(bus.out_valid), 64'd0);

    // Directed table: one op each, flags cleared on accept then ORed on handshake.
    foreach (vecs[i]) begin
      drive_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].lt, vecs[i].eq, vecs[i].exc, vecs[i].rd);
      bus.in_valid = 1; bus.out_ready = 1; bus.fflags_clr = 1;
      @(negedge clk);
      chk("vec_cmp_a", 64'(bus.cmp_a), 64'(vecs[i].a));
      chk("vec_cmp_sig", 64'(bus.cmp_signaling), 64'(vecs[i].op == 3'd1 || vecs[i].op == 3'd2));
      @(posedge clk); #1;
      bus.in_valid = 0; bus.fflags_clr = 0;
      chk("vec_out_valid", 64'(bus.out_valid), 64'd1);
      chk("vec_out_data", 64'(bus.out_data), 64'(vecs[i].exp_d));
      chk("vec_out_rd", 64'(bus.out_rd), 64'(vecs[i].rd));
      chk("vec_out_exc", 64'(bus.out_exc), 64'(vecs[i].exp_e));
      @(posedge clk); #1;
      chk("vec_fflags", 64'(bus.fflags_acc), 64'(vecs[i].exp_e));
      chk("vec_drained", 64'(bus.out_valid), 64'd0);
    end

    // Stall sequence: 4 back-to-back ops, out_ready low for the first 3 cycles.
    do_reset();
    k_in = 0; k_out = 0; acc_stall = 0;
    for (cyc = 0; cyc < 30 && k_out < 4; cyc++) begin
      drive_op(3'd3, 33'h080000000 + 33'(k_in), 33'h080800000, 1'b1, 1'b0, 5'(k_in), 5'(k_in));
      bus.in_valid = (k_in < 4);
      bus.out_ready = (cyc >= 3);
      @(negedge clk);
      if (bus.out_valid) begin
        chk("stall_data", 64'(bus.out_data), 64'(33'h080000000 + 33'(k_out)));
        chk("stall_rd", 64'(bus.out_rd), 64'(k_out));
      end
      if (bus.out_valid && bus.out_ready) k_out++;
      if (bus.in_valid && bus.in_ready) begin
        k_in++;
        if (cyc < 3) acc_stall++;
      end
      @(posedge clk); #1;
    end
`ifdef FP_CMP_STAGE_SKID_EN
    chk("stall_accepted", 64'(acc_stall), 64'd2);
`else
    chk("stall_accepted", 64'(acc_stall), 64'd1);
`endif
    chk("stall_all_out", 64'(k_out), 64'd4);
    bus.in_valid = 0;

    // Clear together with a handshake: prior 01, handshake carries 10 -> 10.
    bus.out_ready = 1; bus.fflags_clr = 1;
    @(posedge clk); #1;
    bus.fflags_clr = 0;
    drive_op(3'd0, 33'h0, 33'h0, 1'b0, 1'b1, 5'h01, 5'd1);
    bus.in_valid = 1;
    @(posedge clk); #1;
    bus.in_valid = 0;
    @(posedge clk); #1;
    chk("flags_prior", 64'(bus.fflags_acc), 64'h01);
    drive_op(3'd1, 33'h0, 33'h0, 1'b0, 1'b0, 5'h10, 5'd2);
    bus.in_valid = 1;
    @(posedge clk); #1;
    bus.in_valid = 0; bus.fflags_clr = 1;
    @(negedge clk);
    chk("flags_clr_hs_valid", 64'(bus.out_valid & bus.out_ready), 64'd1);
    @(posedge clk); #1;
    bus.fflags_clr = 0;
    chk("flags_clr_then_or", 64'(bus.fflags_acc), 64'h10);

    // Reset during a stall drops the buffered result.
    bus.out_ready = 0;
    drive_op(3'd4, 33'h080000000, 33'h080800000, 1'b1, 1'b0, 5'h01, 5'd9);
    bus.in_valid = 1;
    @(posedge clk); #1;
    bus.in_valid = 0;
    chk("stall_pre_reset_valid", 64'(bus.out_valid), 64'd1);
    rst = 1;
    @(posedge clk); #1;
    chk("reset_stall_valid", 64'(bus.out_valid), 64'd0);
    chk("reset_stall_data", 64'(bus.out_data), 64'd0);
    rst = 0; bus.out_ready = 1;
    @(posedge clk); #1;
    chk("reset_stall_stays_empty", 64'(bus.out_valid), 64'd0);

    // Randomized scoreboard run against the reference model.
    do_reset();
    sb.delete();
    fl = '0;
    for (int c = 0; c < 600; c++) begin
      lt_eq = $urandom_range(0, 2);
      drive_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
               lt_eq == 0, lt_eq == 1, ($urandom_range(0, 1) != 0) ? 5'($urandom) : 5'h0,
               5'($urandom));
      bus.in_valid   = ($urandom_range(0, 3) != 0);
      bus.out_ready  = ($urandom_range(0, 2) != 0);
      bus.fflags_clr = ($urandom_range(0, 15) == 0);
      @(negedge clk);
      chk("rnd_cmp_b", 64'(bus.cmp_b), 64'(bus.in_b));
      chk("rnd_cmp_sig", 64'(bus.cmp_signaling), 64'(bus.in_op == 3'd1 || bus.in_op == 3'd2));
`ifdef FP_CMP_STAGE_SKID_EN
      chk("rnd_in_ready", 64'(bus.in_ready), 64'(sb.size() < 2));
`else
      chk("rnd_in_ready", 64'(bus.in_ready), 64'(sb.size() == 0 || bus.out_ready));
`endif
      chk("rnd_out_valid", 64'(bus.out_valid), 64'(sb.size() != 0));
      fire = bus.out_valid & bus.out_ready;
      acc  = bus.in_valid & bus.in_ready;
      if (bus.out_valid && sb.size() != 0) begin
        head = sb[0];
        chk("rnd_out_data", 64'(bus.out_data), 64'(head.d));
        chk("rnd_out_rd", 64'(bus.out_rd), 64'(head.rd));
        chk("rnd_out_exc", 64'(bus.out_exc), 64'(head.e));
      end
      if (bus.fflags_clr) fl = '0;
      if (fire && sb.size() != 0) begin
        fl = fl | sb[0].e;
        void'(sb.pop_front());
      end
      if (acc) begin
        model(bus.in_op, bus.in_a, bus.in_b, bus.cmp_lt, bus.cmp_eq, bus.cmp_exc, ed, ee);
        sb.push_back('{d: ed, rd: bus.in_rd, e: ee});
      end
      @(posedge clk); #1;
      chk("rnd_fflags", 64'(bus.fflags_acc), 64'(fl));
    end

    // Drain with a bounded wait.
    bus.in_valid = 0; bus.out_ready = 1; bus.fflags_clr = 0;
    for (int c = 0; c < 10 && sb.size() != 0; c++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        chk("drain_data", 64'(bus.out_data), 64'(sb[0].d));
        void'(sb.pop_front());
      end
    end
    chk("drain_empty", 64'(sb.size()), 64'd0);
    @(negedge clk);
    chk("drain_no_extra", 64'(bus.out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_cmp_stage.md
FP_CMP_STAGE -- requirements
Module: fp_cmp_stage

Interface
REQ-001 SHALL have port clock, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have ports in_valid (input, 1) and in_ready (output, 1), the issue handshake.
REQ-004 SHALL have ports in_op (input, 3) and in_rd (input, 5). in_op codes: 0 FEQ, 1 FLT, 2 FLE, 3 FMIN, 4 FMAX, 5-7 illegal. in_rd is the destination tag.
REQ-005 SHALL have ports in_a and in_b (input, 33 each), recoded single-precision operands.
REQ-006 SHALL have ports cmp_a and cmp_b (output, 33 each) and cmp_signaling (output, 1), driven to the downstream recoded comparator.
REQ-007 SHALL have ports cmp_lt and cmp_eq (input, 1 each) and cmp_exc (input, 5), the comparator results, valid in the same cycle as its inputs.
REQ-008 SHALL have ports out_valid (output, 1) and out_ready (input, 1), the writeback handshake.
REQ-009 SHALL have ports out_data (output, 33), out_rd (output, 5) and out_exc (output, 5).
REQ-010 SHALL have ports fflags_acc (output, 5), sticky accrued flags, and fflags_clr (input, 1), which clears them.

Function
REQ-011 SHALL drive cmp_a=in_a and cmp_b=in_b combinationally; cmp_signaling=1 for FLT/FLE, else 0.
REQ-012 SHALL accept an operation on a cycle where in_valid and in_ready are both 1, and SHALL register its result; out_valid rises on the next cycle (latency 1).
REQ-013 SHALL give FEQ/FLT/FLE results zero-extended to 33 bits: FEQ=cmp_eq, FLT=cmp_lt, FLE=cmp_lt|cmp_eq.
REQ-014 SHALL classify an operand as NaN when bits[31:29]=3'b111, and as signaling NaN when it is NaN and bit22=0.
REQ-015 SHALL compute FMIN/FMAX as follows: both operands NaN -> canonical NaN 33'h0E0400000; exactly one NaN -> the other operand; otherwise FMIN -> a if cmp_lt else b, FMAX -> b if cmp_lt else a.
REQ-016 SHALL make FMIN select the operand with sign=1 (FMAX: sign=0) when cmp_eq=1 and the operand signs differ.
REQ-017 SHALL make out_exc=cmp_exc for ops 0-4; illegal ops SHALL yield out_data=0 and out_exc=5'h10.
REQ-018 SHALL hold out_data, out_rd and out_exc stable while out_valid=1 and out_ready=0.
REQ-019 SHALL OR out_exc into fflags_acc on each output handshake (out_valid & out_ready).
REQ-020 SHALL clear fflags_acc when fflags_clr=1; if a handshake occurs in the same cycle, fflags_acc SHALL become that handshake's out_exc (clear first, then OR).
REQ-021 SHALL preserve in-order delivery, with no loss or duplication under any in_valid/out_ready pattern.

Reset
REQ-022 SHALL, on reset, set out_valid=0, out_data=0, out_rd=0, out_exc=0 and fflags_acc=0, and empty all buffer entries.
REQ-023 SHALL discard an operation accepted in the same cycle reset is asserted; in_ready SHALL be 0 while reset=1.
REQ-024 SHALL hold out_valid=0 after reset until a new handshake completes; reset mid-stall SHALL drop the buffered result.

Configuration
REQ-025 With FP_CMP_STAGE_SKID_EN defined, the stage SHALL use a 2-entry output buffer (main plus skid) with in_ready registered as !skid_full. This sustains 1 op/cycle with out_ready=1; when out_ready drops, exactly one further op SHALL be captured into the skid entry, then in_ready=0.
REQ-026 Without FP_CMP_STAGE_SKID_EN, the stage SHALL use a single output register with in_ready = !out_valid | out_ready (combinational), and SHALL still reach 1 op/cycle throughput.
REQ-027 Both configurations SHALL produce identical out_data/out_rd/out_exc sequences for identical accepted inputs.

Verification
REQ-028 FLT a=33'h080000000 (1.0), b=33'h080800000 (2.0), cmp_lt=1 -> next cycle out_data=1, out_exc=0.
REQ-029 FMIN a=33'h100000000 (-0), b=33'h000000000 (+0), cmp_eq=1 -> out_data=33'h100000000; FMAX with the same operands -> 33'h000000000.
REQ-030 FMAX a=33'h0E0000001 (sNaN), b=33'h180000000 (-1.0), cmp_exc=5'h10 -> out_data=33'h180000000, out_exc=5'h10, fflags_acc=5'h10 after the handshake.
REQ-031 FMIN with both operands 33'h0E0400000 -> out_data=33'h0E0400000; in_op=6 -> out_data=0, out_exc=5'h10.
REQ-032 Back-to-back 4 ops with out_ready held 0 for 3 cycles: SKID_EN accepts 2 then deasserts in_ready; results emerge in order with stable data during the stall.
REQ-033 fflags_clr asserted together with a handshake carrying out_exc=5'h10, prior accrued 5'h01 -> fflags_acc=5'h10; reset asserted during a stall -> out_valid=0 the next cycle.
